mem_byte_initiator: RTL and testbench
=====================================

Name: mem_byte_initiator

Overview:
- Load/store access sequencer between the multi-cycle CPU's MEM state and a byte-wide, big-endian data memory port.
- Converts one byte, halfword or word request into 1, 2 or 4 serial byte transactions using a req/ack handshake.
- Assembles read bytes most-significant first and sign- or zero-extends the result.
- Pulses done for one cycle when the access completes.

Parameters:
- ADDR_W, 32, width of the CPU-side and memory-side byte address.
- MEM_BYTES, 128, number of bytes on the memory port. An access whose last byte address is >= MEM_BYTES is an out-of-range error.

Ports:
- CLK  in  1  system clock; all state updates on the rising edge.
- Rst  in  1  synchronous, active-high reset.
- start  in  1  request strobe; sampled only in IDLE.
- we  in  1  1 = store, 0 = load.
- size  in  2  00 byte, 01 halfword, 10 word, 11 reserved.
- uns  in  1  load zero-extend when 1, sign-extend when 0; ignored for word loads and for stores.
- addr  in  ADDR_W  byte address of the most significant byte.
- wdata  in  32  store data, right-aligned (byte in [7:0], halfword in [15:0]).
- busy  out  1  high whenever the state is not IDLE.
- done  out  1  one-cycle completion pulse.
- err  out  1  valid with done; high = access rejected, no memory traffic issued.
- rdata  out  32  extended load result; held until the next accepted load.
- mem_req  out  1  byte transaction request.
- mem_we  out  1  byte write enable.
- mem_addr  out  ADDR_W  byte address.
- mem_wdata  out  8  write byte.
- mem_rdata  in  8  read byte; valid in any cycle where mem_req and mem_ack are both high.
- mem_ack  in  1  transaction accepted/complete at this edge.

Behaviour:
- Reset (synchronous, Rst=1 at an edge):
  - State goes to IDLE; busy, done, err, mem_req, mem_we = 0; mem_addr, mem_wdata, rdata = 0; byte counter and accumulator = 0.
  - Reset mid-access abandons the access with no done pulse.
  - Memory bytes already written stay written.
- States: IDLE, XFER, DONE.
- IDLE:
  - Transition on start=1: latch we, size, uns, addr and wdata.
  - n = 1, 2 or 4. Byte counter k = 0.
  - If the request is rejected, go to DONE with err=1 and never assert mem_req. Rejection cases:
    - size=11;
    - addr + n - 1 >= MEM_BYTES;
    - misalignment, only when the optional feature is enabled.
  - Otherwise go to XFER.
- XFER:
  - mem_req=1. mem_addr = latched addr + k; mem_we = latched we.
  - mem_wdata = byte k of the store operand, most significant first:
    - word: k0=[31:24], k1=[23:16], k2=[15:8], k3=[7:0];
    - half: k0=[15:8], k1=[7:0];
    - byte: [7:0].
  - mem_addr, mem_we and mem_wdata are stable while mem_req=1 and ack=0. Wait states are unlimited.
  - On each edge with mem_ack=1:
    - loads: accumulator <= {acc[23:0], mem_rdata};
    - k increments;
    - if k was n-1, go to DONE.
  - mem_req stays high across consecutive bytes, so there is no idle cycle between bytes.
- DONE:
  - done=1 for exactly one cycle, then IDLE.
  - For an accepted load, rdata updates on the edge entering DONE:
    - LB: sign-extend acc[7:0];
    - LBU: zero-extend acc[7:0];
    - LH: sign-extend acc[15:0];
    - LHU: zero-extend acc[15:0];
    - LW: acc.
  - Stores and rejected accesses leave rdata unchanged.
  - err is valid only while done=1, otherwise 0.
- Latency with mem_ack tied high:
  - start sampled at edge E0; byte transfers at E1..En; done high in the cycle after En. Word load = 5 cycles from start to done.
  - Rejected access: done in the cycle after E0.
- start is ignored while busy=1, including during DONE. There is no queueing.
- Address arithmetic is modulo 2^ADDR_W. A wrapped address makes the last-byte check fail, and the access is rejected.
- mem_ack with mem_req=0 is ignored.

Optional Feature:
- Macro: MEM_ALIGN_CHECK_EN.
- Defined: a halfword with addr[0]=1, or a word with addr[1:0]!=00, is rejected: done with err=1, no mem_req.
- Undefined: misaligned accesses are performed byte-serially like any other access. err is raised only for size=11 or out-of-range.

Test Plan:
- SW addr=4, wdata=0x12345678, ack tied 1 -> mem_addr 4,5,6,7 with wdata 12,34,56,78 on four consecutive edges; done 5 cycles after start; err=0.
- LW addr=4 after that store, memory model returns the stored bytes -> rdata=0x12345678; then LB addr=4 -> 0x00000012; LH addr=6 -> 0x00005678.
- Memory holds 0x80,0xFF at 8,9 -> LB addr=8 gives 0xFFFFFF80; LBU gives 0x00000080; LH gives 0xFFFF80FF; LHU gives 0x000080FF.
- Memory model inserts 2 wait cycles on byte 1 of a word load -> mem_addr holds at addr+1 for 3 cycles; result is correct; done 7 cycles after start; start pulses during busy are ignored.
- LW addr=126 (MEM_BYTES=128) -> done with err=1 one cycle after start, mem_req never high; LW addr=5 -> err=1 with MEM_ALIGN_CHECK_EN defined, 4 transfers at 5..8 and err=0 without it.
- Rst asserted during byte 2 of an SW -> next edge busy=0, mem_req=0, no done pulse; a subsequent LB completes normally.

Source files
------------

// File: rtl/mem_byte_initiator.sv
// Byte-serial load/store sequencer between the CPU MEM state and a big-endian byte memory port.
// Optional build macro MEM_ALIGN_CHECK_EN rejects misaligned halfword/word accesses.
module mem_byte_initiator #(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned MEM_BYTES = 128
) (
    input  logic              CLK,
    input  logic              Rst,
    input  logic              start,
    input  logic              we,
    input  logic [1:0]        size,
    input  logic              uns,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [31:0]       rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    input  logic              mem_ack
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_XFER = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    localparam logic [ADDR_W:0] MEM_LIM = (ADDR_W + 1)'(MEM_BYTES);

    state_t              state_r, state_s;
    logic [2:0]          k_r, k_s;
    logic [31:0]         acc_r, acc_s;
    logic                accept_s, reject_s, misalign_s;
    logic [ADDR_W:0]     last_addr_s;
    logic                we_r, uns_r, we_nx_s, uns_nx_s;
    logic [1:0]          size_r, size_nx_s;
    logic [ADDR_W-1:0]   addr_r, addr_nx_s;
    logic [31:0]         wdata_r, wdata_nx_s;

    function automatic logic [2:0] last_index(input logic [1:0] sz);
        case (sz)
            2'b00:   last_index = 3'd0;
            2'b01:   last_index = 3'd1;
            2'b10:   last_index = 3'd3;
            default: last_index = 3'd0;
        endcase
    endfunction

    function automatic logic [7:0] store_byte(input logic [1:0] sz, input logic [1:0] k,
                                              input logic [31:0] wd);
        case (sz)
            2'b10: begin
                case (k)
                    2'd0:    store_byte = wd[31:24];
                    2'd1:    store_byte = wd[23:16];
                    2'd2:    store_byte = wd[15:8];
                    default: store_byte = wd[7:0];
                endcase
            end
            2'b01:   store_byte = (k[0] == 1'b0) ? wd[15:8] : wd[7:0];
            default: store_byte = wd[7:0];
        endcase
    endfunction

    function automatic logic [31:0] load_extend(input logic [1:0] sz, input logic u,
                                                input logic [31:0] a);
        case (sz)
            2'b00:   load_extend = u ? {24'h000000, a[7:0]} : {{24{a[7]}}, a[7:0]};
            2'b01:   load_extend = u ? {16'h0000, a[15:0]} : {{16{a[15]}}, a[15:0]};
            default: load_extend = a;
        endcase
    endfunction

    // Request screening; the extra address bit catches wrap-around as out of range.
    always_comb begin
        last_addr_s = {1'b0, addr} + {{(ADDR_W - 2){1'b0}}, last_index(size)};
`ifdef MEM_ALIGN_CHECK_EN
        misalign_s = ((size == 2'b01) && (addr[0] == 1'b1)) ||
                     ((size == 2'b10) && (addr[1:0] != 2'b00));
`else
        misalign_s = 1'b0;
`endif
        reject_s = (size == 2'b11) || (last_addr_s >= MEM_LIM) || misalign_s;
    end

    // Next-state, byte counter and read accumulator.
    always_comb begin
        state_s  = state_r;
        k_s      = k_r;
        acc_s    = acc_r;
        accept_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start == 1'b1) begin
                    accept_s = 1'b1;
                    k_s      = 3'd0;
                    acc_s    = 32'h0000_0000;
                    if (reject_s) begin
                        state_s = ST_DONE;
                    end else begin
                        state_s = ST_XFER;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_XFER: begin
                if (mem_ack == 1'b1) begin
                    k_s = k_r + 3'd1;
                    if (we_r == 1'b0) begin
                        acc_s = {acc_r[23:0], mem_rdata};
                    end else begin
                        acc_s = acc_r;
                    end
                    if (k_r == last_index(size_r)) begin
                        state_s = ST_DONE;
                    end else begin
                        state_s = ST_XFER;
                    end
                end else begin
                    state_s = ST_XFER;
                end
            end
            ST_DONE: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // Request fields as they will be seen after this edge.
    always_comb begin
        if (accept_s) begin
            we_nx_s    = we;
            size_nx_s  = size;
            uns_nx_s   = uns;
            addr_nx_s  = addr;
            wdata_nx_s = wdata;
        end else begin
            we_nx_s    = we_r;
            size_nx_s  = size_r;
            uns_nx_s   = uns_r;
            addr_nx_s  = addr_r;
            wdata_nx_s = wdata_r;
        end
    end

    // State, latched request and registered outputs (all derived from next-state values).
    always_ff @(posedge CLK) begin
        if (Rst) begin
            state_r   <= ST_IDLE;
            k_r       <= 3'd0;
            acc_r     <= 32'h0000_0000;
            we_r      <= 1'b0;
            size_r    <= 2'b00;
            uns_r     <= 1'b0;
            addr_r    <= '0;
            wdata_r   <= 32'h0000_0000;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            rdata     <= 32'h0000_0000;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= 8'h00;
        end else begin
            state_r <= state_s;
            k_r     <= k_s;
            acc_r   <= acc_s;
            we_r    <= we_nx_s;
            size_r  <= size_nx_s;
            uns_r   <= uns_nx_s;
            addr_r  <= addr_nx_s;
            wdata_r <= wdata_nx_s;
            busy    <= (state_s != ST_IDLE);
            done    <= (state_s == ST_DONE);
            err     <= accept_s & reject_s;
            mem_req <= (state_s == ST_XFER);
            mem_we  <= (state_s == ST_XFER) ? we_nx_s : 1'b0;
            if (state_s == ST_XFER) begin
                mem_addr  <= addr_nx_s + ADDR_W'(k_s);
                mem_wdata <= store_byte(size_nx_s, k_s[1:0], wdata_nx_s);
            end
            if ((state_r == ST_XFER) && (state_s == ST_DONE) && (we_r == 1'b0)) begin
                rdata <= load_extend(size_r, uns_r, acc_s);
            end
        end
    end

endmodule

// File: tb/tb_mem_byte_initiator.sv
// Directed self-checking bench for mem_byte_initiator with a 128-byte memory model.
module tb_mem_byte_initiator;

    logic        CLK = 1'b0;
    logic        Rst, start, we, uns, busy, done, err, mem_req, mem_we, mem_ack;
    logic [1:0]  size;
    logic [31:0] addr, wdata, rdata, mem_addr;
    logic [7:0]  mem_wdata, mem_rdata;
    logic [7:0]  mem [0:127];

    int checks = 0;
    int errors = 0;

    int          res_cycles, res_reqcyc, res_stallcyc, res_nx, stall_left;
    logic        res_err, res_to, pulse_start;
    logic [31:0] res_rdata, stall_addr;
    logic [31:0] log_addr [0:7];
    logic [7:0]  log_wd [0:7];
    logic        log_we [0:7];

    always #5 CLK = ~CLK;

    mem_byte_initiator #(.ADDR_W(32), .MEM_BYTES(128)) dut (
        .CLK(CLK), .Rst(Rst), .start(start), .we(we), .size(size), .uns(uns),
        .addr(addr), .wdata(wdata), .busy(busy), .done(done), .err(err), .rdata(rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    assign mem_rdata = (mem_addr < 32'd128) ? mem[mem_addr[6:0]] : 8'h00;

    always @(posedge CLK) begin
        if (mem_req && mem_ack && mem_we && (mem_addr < 32'd128)) mem[mem_addr[6:0]] <= mem_wdata;
    end

    // Issues one request and records the transfers; all checks are done by the callers.
    task automatic run_access(input logic w, input logic [1:0] sz, input logic u,
                              input logic [31:0] a, input logic [31:0] wd);
        res_reqcyc = 0; res_stallcyc = 0; res_nx = 0;
        @(negedge CLK);
        we = w; size = sz; uns = u; addr = a; wdata = wd; start = 1'b1; mem_ack = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        res_cycles = 0;
        while (!done && res_cycles < 50) begin
            if (mem_req) res_reqcyc++;
            if (mem_req && mem_addr == stall_addr) res_stallcyc++;
            if (stall_left > 0 && mem_req && mem_addr == stall_addr) begin
                mem_ack = 1'b0;
                stall_left--;
            end else begin
                mem_ack = 1'b1;
            end
            if (mem_req && mem_ack && res_nx < 8) begin
                log_addr[res_nx] = mem_addr; log_wd[res_nx] = mem_wdata; log_we[res_nx] = mem_we;
                res_nx++;
            end
            if (pulse_start) begin
                start = ~start; we = 1'b1; size = 2'b00; addr = 32'd100;
            end
            @(negedge CLK);
            res_cycles++;
        end
        res_to = !done; res_err = err; res_rdata = rdata;
        start = 1'b0; mem_ack = 1'b1;
    endtask

    task automatic test_reset();
        Rst = 1'b1; start = 1'b0; we = 1'b0; uns = 1'b0; size = 2'b00;
        addr = 32'd0; wdata = 32'd0; mem_ack = 1'b1;
        repeat (2) @(negedge CLK);
        checks++;
        if ({busy, done, err, mem_req, mem_we} !== 5'b00000) begin
            errors++; $display("FAIL reset_ctrl got %b want 00000", {busy, done, err, mem_req, mem_we});
        end
        checks++;
        if ({mem_addr, mem_wdata, rdata} !== 72'h0) begin
            errors++; $display("FAIL reset_data got %h/%h/%h want 0", mem_addr, mem_wdata, rdata);
        end
        Rst = 1'b0;
    endtask

    task automatic test_store_word();
        logic [7:0] exp_b [0:3];
        exp_b[0] = 8'h12; exp_b[1] = 8'h34; exp_b[2] = 8'h56; exp_b[3] = 8'h78;
        run_access(1'b1, 2'b10, 1'b0, 32'd4, 32'h1234_5678);
        checks++;
        if (res_to || res_cycles != 4 || res_err !== 1'b0 || res_nx != 4) begin
            errors++; $display("FAIL sw_timing got to=%0d cyc=%0d err=%b nx=%0d want 0/4/0/4",
                               res_to, res_cycles, res_err, res_nx);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (log_addr[i] !== 32'd4 + i || log_wd[i] !== exp_b[i] || log_we[i] !== 1'b1) begin
                errors++; $display("FAIL sw_byte%0d got a=%0d d=%h we=%b want a=%0d d=%h we=1",
                                   i, log_addr[i], log_wd[i], log_we[i], 4 + i, exp_b[i]);
            end
        end
    endtask

    task automatic test_load_basic();
        run_access(1'b0, 2'b10, 1'b0, 32'd4, 32'h0);
        checks++;
        if (res_to || res_cycles != 4 || res_rdata !== 32'h1234_5678 || log_we[0] !== 1'b0) begin
            errors++; $display("FAIL lw4 got cyc=%0d rdata=%h we=%b want 4/12345678/0",
                               res_cycles, res_rdata, log_we[0]);
        end
        run_access(1'b0, 2'b00, 1'b0, 32'd4, 32'h0);
        checks++;
        if (res_to || res_cycles != 1 || res_rdata !== 32'h0000_0012) begin
            errors++; $display("FAIL lb4 got cyc=%0d rdata=%h want 1/00000012", res_cycles, res_rdata);
        end
        run_access(1'b0, 2'b01, 1'b0, 32'd6, 32'h0);
        checks++;
        if (res_to || res_cycles != 2 || res_rdata !== 32'h0000_5678 || log_addr[1] !== 32'd7) begin
            errors++; $display("FAIL lh6 got cyc=%0d rdata=%h a1=%0d want 2/00005678/7",
                               res_cycles, res_rdata, log_addr[1]);
        end
    endtask

    task automatic test_extend();
        logic [1:0]  t_sz [0:3];
        logic        t_u  [0:3];
        logic [31:0] t_exp [0:3];
        t_sz[0] = 2'b00; t_u[0] = 1'b0; t_exp[0] = 32'hFFFF_FF80;
        t_sz[1] = 2'b00; t_u[1] = 1'b1; t_exp[1] = 32'h0000_0080;
        t_sz[2] = 2'b01; t_u[2] = 1'b0; t_exp[2] = 32'hFFFF_80FF;
        t_sz[3] = 2'b01; t_u[3] = 1'b1; t_exp[3] = 32'h0000_80FF;
        run_access(1'b1, 2'b01, 1'b0, 32'd8, 32'h5555_80FF);
        checks++;
        if (res_nx != 2 || log_wd[0] !== 8'h80 || log_wd[1] !== 8'hFF || log_addr[1] !== 32'd9) begin
            errors++; $display("FAIL sh8 got nx=%0d d0=%h d1=%h a1=%0d want 2/80/ff/9",
                               res_nx, log_wd[0], log_wd[1], log_addr[1]);
        end
        for (int i = 0; i < 4; i++) begin
            run_access(1'b0, t_sz[i], t_u[i], 32'd8, 32'h0);
            checks++;
            if (res_to || res_err !== 1'b0 || res_rdata !== t_exp[i]) begin
                errors++; $display("FAIL ext%0d got rdata=%h err=%b want %h/0", i, res_rdata, res_err, t_exp[i]);
            end
        end
    endtask

    task automatic test_wait_states();
        run_access(1'b1, 2'b10, 1'b0, 32'd0, 32'hCAFE_F00D);
        stall_addr = 32'd1; stall_left = 2; pulse_start = 1'b1;
        run_access(1'b0, 2'b10, 1'b0, 32'd0, 32'h0);
        pulse_start = 1'b0; stall_addr = 32'hFFFF_FFFF;
        checks++;
        if (res_to || res_cycles != 6 || res_stallcyc != 3 || res_nx != 4) begin
            errors++; $display("FAIL wait_timing got cyc=%0d hold=%0d nx=%0d want 6/3/4",
                               res_cycles, res_stallcyc, res_nx);
        end
        checks++;
        if (res_rdata !== 32'hCAFE_F00D || log_addr[1] !== 32'd1 || log_addr[3] !== 32'd3) begin
            errors++; $display("FAIL wait_data got rdata=%h a1=%0d a3=%0d want cafef00d/1/3",
                               res_rdata, log_addr[1], log_addr[3]);
        end
        @(negedge CLK);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || mem_req !== 1'b0) begin
            errors++; $display("FAIL wait_idle got busy=%b done=%b req=%b want 000", busy, done, mem_req);
        end
    endtask

    task automatic test_reject();
        run_access(1'b0, 2'b10, 1'b0, 32'd126, 32'h0);
        checks++;
        if (res_to || res_cycles != 0 || res_err !== 1'b1 || res_reqcyc != 0 || res_rdata !== 32'hCAFE_F00D) begin
            errors++; $display("FAIL lw126 got cyc=%0d err=%b req=%0d rdata=%h want 0/1/0/cafef00d",
                               res_cycles, res_err, res_reqcyc, res_rdata);
        end
        @(negedge CLK);
        checks++;
        if (err !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL err_clear got err=%b done=%b want 0/0", err, done);
        end
        run_access(1'b0, 2'b11, 1'b0, 32'd0, 32'h0);
        checks++;
        if (res_cycles != 0 || res_err !== 1'b1 || res_reqcyc != 0) begin
            errors++; $display("FAIL size11 got cyc=%0d err=%b req=%0d want 0/1/0", res_cycles, res_err, res_reqcyc);
        end
        run_access(1'b0, 2'b01, 1'b0, 32'hFFFF_FFFF, 32'h0);
        checks++;
        if (res_cycles != 0 || res_err !== 1'b1 || res_reqcyc != 0) begin
            errors++; $display("FAIL wrap got cyc=%0d err=%b req=%0d want 0/1/0", res_cycles, res_err, res_reqcyc);
        end
        run_access(1'b1, 2'b00, 1'b0, 32'd127, 32'h0000_005A);
        checks++;
        if (res_err !== 1'b0 || res_nx != 1 || log_addr[0] !== 32'd127 || log_wd[0] !== 8'h5A) begin
            errors++; $display("FAIL sb127 got err=%b nx=%0d a=%0d d=%h want 0/1/127/5a",
                               res_err, res_nx, log_addr[0], log_wd[0]);
        end
        run_access(1'b0, 2'b10, 1'b0, 32'd5, 32'h0);
`ifdef MEM_ALIGN_CHECK_EN
        checks++;
        if (res_cycles != 0 || res_err !== 1'b1 || res_reqcyc != 0) begin
            errors++; $display("FAIL lw5_align got cyc=%0d err=%b req=%0d want 0/1/0", res_cycles, res_err, res_reqcyc);
        end
`else
        checks++;
        if (res_cycles != 4 || res_err !== 1'b0 || res_nx != 4 || log_addr[0] !== 32'd5 ||
            log_addr[3] !== 32'd8 || res_rdata !== 32'h3456_7880) begin
            errors++; $display("FAIL lw5 got cyc=%0d err=%b nx=%0d a0=%0d a3=%0d rdata=%h want 4/0/4/5/8/34567880",
                               res_cycles, res_err, res_nx, log_addr[0], log_addr[3], res_rdata);
        end
`endif
    endtask

    task automatic test_reset_mid();
        @(negedge CLK);
        we = 1'b1; size = 2'b10; uns = 1'b0; addr = 32'd12; wdata = 32'hAABB_CCDD;
        start = 1'b1; mem_ack = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        repeat (2) @(negedge CLK);
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'd14 || mem_wdata !== 8'hCC) begin
            errors++; $display("FAIL mid_byte2 got req=%b a=%0d d=%h want 1/14/cc", mem_req, mem_addr, mem_wdata);
        end
        Rst = 1'b1;
        @(negedge CLK);
        checks++;
        if (busy !== 1'b0 || mem_req !== 1'b0 || done !== 1'b0 || rdata !== 32'h0) begin
            errors++; $display("FAIL mid_reset got busy=%b req=%b done=%b rdata=%h want 0/0/0/0",
                               busy, mem_req, done, rdata);
        end
        Rst = 1'b0;
        @(negedge CLK);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL mid_nodone got done=%b busy=%b want 0/0", done, busy);
        end
        run_access(1'b0, 2'b00, 1'b0, 32'd12, 32'h0);
        checks++;
        if (res_to || res_err !== 1'b0 || res_cycles != 1 || res_rdata !== 32'hFFFF_FFAA) begin
            errors++; $display("FAIL post_reset_lb got cyc=%0d err=%b rdata=%h want 1/0/ffffffaa",
                               res_cycles, res_err, res_rdata);
        end
    endtask

    initial begin
        stall_addr = 32'hFFFF_FFFF; stall_left = 0; pulse_start = 1'b0;
        test_reset();
        test_store_word();
        test_load_basic();
        test_extend();
        test_wait_states();
        test_reject();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
